// File: rtl/lfsr_rng_ranged.sv
// Galois-LFSR random source that answers range-limited draw requests.
// Rejection sampling against a power-of-two mask, with a subtractive fallback after MAX_TRIES.
module lfsr_rng_ranged #(
  parameter int                WIDTH          = 16,
  parameter logic [WIDTH-1:0]  TAPS           = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED           = 16'hACE1,
  parameter int                OUT_W          = 10,
  parameter int                STEPS_PER_DRAW = 1,
  parameter int                MAX_TRIES      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [OUT_W-1:0] req_max_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [OUT_W-1:0] rsp_data_o,
  output logic             rsp_fallback_o,
  output logic [WIDTH-1:0] random_o
);

  localparam int STEP_W = (STEPS_PER_DRAW > 1) ? $clog2(STEPS_PER_DRAW) : 1;
  localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_DRAW - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   lfsr_q;
  logic [OUT_W-1:0]   max_q;
  logic [OUT_W-1:0]   mask_q;
  logic [TRY_W-1:0]   tryCnt_q;
  logic [STEP_W-1:0]  stepCnt_q;
  logic [OUT_W-1:0]   rspData_q;
  logic               rspFallback_q;
  logic               rspValid_q;

  logic [WIDTH-1:0]   lfsr_d;
  logic [OUT_W-1:0]   maskFold;
  logic [OUT_W-1:0]   candidate;
  logic [OUT_W-1:0]   fallbackVal;
  logic [WIDTH-1:0]   seedGuarded;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    maskFold = req_max_i;
    for (int i = 0; i < OUT_W; i++) begin
      maskFold = maskFold | (maskFold >> 1);
    end
    candidate = lfsr_d[OUT_W-1:0] & mask_q;
    // Only used when candidate > max, so max+1 cannot wrap and the result stays below max+1.
    fallbackVal = candidate - max_q - OUT_W'(1);
    seedGuarded = (seed_in_i == '0) ? SEED : seed_in_i;
  end

  assign req_ready_o    = !rst_i && (state_q == IDLE) && !seed_load_i;
  assign rsp_valid_o    = rspValid_q;
  assign rsp_data_o     = rspData_q;
  assign rsp_fallback_o = rspFallback_q;
  assign random_o       = lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      max_q         <= '0;
      mask_q        <= '0;
      tryCnt_q      <= '0;
      stepCnt_q     <= '0;
      rspData_q     <= '0;
      rspFallback_q <= 1'b0;
      rspValid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_load_i) begin
            lfsr_q <= seedGuarded;
          end else if (req_valid_i) begin
            max_q     <= req_max_i;
            mask_q    <= maskFold;
            tryCnt_q  <= '0;
            stepCnt_q <= '0;
            state_q   <= DRAW;
          end else if (enable_i) begin
            lfsr_q <= lfsr_d;
          end
        end
        DRAW: begin
          lfsr_q <= lfsr_d;
          if (stepCnt_q == STEP_LAST) begin
            if (candidate <= max_q) begin
              rspData_q     <= candidate;
              rspFallback_q <= 1'b0;
              rspValid_q    <= 1'b1;
              state_q       <= DONE;
            end else if (tryCnt_q == TRY_LAST) begin
              rspData_q     <= fallbackVal;
              rspFallback_q <= 1'b1;
              rspValid_q    <= 1'b1;
              state_q       <= DONE;
            end else begin
              tryCnt_q  <= tryCnt_q + 1'b1;
              stepCnt_q <= '0;
            end
          end else begin
            stepCnt_q <= stepCnt_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_ranged.sv
// Scoreboard bench: directed draws with hand-derived results, a MAX_TRIES=1 instance for the fallback path,
// reset-in-flight checks and a range-only random sweep.
module tb_lfsr_rng_ranged;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, seed_load, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fallback;
  logic [15:0] seed_in, random;
  logic [7:0]  req_max, rsp_data;

  logic        bEnable, bSeedLoad, bReqValid, bReqReady, bRspValid, bRspReady, bRspFallback;
  logic [15:0] bSeedIn, bRandom;
  logic [7:0]  bReqMax, bRspData;

  lfsr_rng_ranged #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .OUT_W(8), .STEPS_PER_DRAW(1), .MAX_TRIES(4)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .seed_load_i(seed_load), .seed_in_i(seed_in),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_max_i(req_max),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_fallback_o(rsp_fallback), .random_o(random)
  );

  lfsr_rng_ranged #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .OUT_W(8), .STEPS_PER_DRAW(1), .MAX_TRIES(1)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .enable_i(bEnable), .seed_load_i(bSeedLoad), .seed_in_i(bSeedIn),
    .req_valid_i(bReqValid), .req_ready_o(bReqReady), .req_max_i(bReqMax),
    .rsp_valid_o(bRspValid), .rsp_ready_i(bRspReady), .rsp_data_o(bRspData),
    .rsp_fallback_o(bRspFallback), .random_o(bRandom)
  );

  typedef struct {
    logic [7:0] data;
    logic       fb;
    int         lat;
    bit         rangeOnly;
    logic [7:0] max;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  int   assertions = 0;
  int   failures = 0;
  int   cyc = 0;
  int   expCntA = 0, respCntA = 0, expCntB = 0, respCntB = 0;
  int   accA = 0, latA = 0, accB = 0, latB = 0;
  logic prevA = 1'b0, prevB = 1'b0;

  always @(posedge clk) cyc++;

  function automatic exp_t mkExp(input logic [7:0] d, input logic fb, input int lat,
                                 input bit rangeOnly, input logic [7:0] mx);
    exp_t e;
    e.data = d; e.fb = fb; e.lat = lat; e.rangeOnly = rangeOnly; e.max = mx;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic scoreResp(input string tag, input exp_t e, input logic [7:0] d, input logic fb, input int lat);
    if (e.rangeOnly) begin
      assertions++;
      if (d > e.max) begin
        failures++;
        $display("[TB] FAIL %s_range: got %0d, expected <= %0d", tag, d, e.max);
      end
      assertions++;
      if (lat < 1 || lat > 4) begin
        failures++;
        $display("[TB] FAIL %s_latency: got %0d, expected 1..4", tag, lat);
      end
    end else begin
      checkOutput({tag, "_data"}, {8'h00, d}, {8'h00, e.data});
      checkOutput({tag, "_fallback"}, {15'h0, fb}, {15'h0, e.fb});
      checkOutput({tag, "_latency"}, 16'(lat), 16'(e.lat));
    end
  endtask

  // Monitors sample on the falling edge; stimulus only changes just after the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prevA = 1'b0;
    end else begin
      if (req_valid && req_ready) accA = cyc + 1;
      if (rsp_valid && !prevA) latA = cyc - accA;
      prevA = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (qA.size() == 0) begin
          assertions++; failures++;
          $display("[TB] FAIL unexpected_rspA: got data %h, expected no response", rsp_data);
        end else begin
          scoreResp("rspA", qA.pop_front(), rsp_data, rsp_fallback, latA);
        end
        respCntA++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prevB = 1'b0;
    end else begin
      if (bReqValid && bReqReady) accB = cyc + 1;
      if (bRspValid && !prevB) latB = cyc - accB;
      prevB = bRspValid;
      if (bRspValid && bRspReady) begin
        if (qB.size() == 0) begin
          assertions++; failures++;
          $display("[TB] FAIL unexpected_rspB: got data %h, expected no response", bRspData);
        end else begin
          scoreResp("rspB", qB.pop_front(), bRspData, bRspFallback, latB);
        end
        respCntB++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] mx, input bit push, input logic [7:0] ed,
                               input logic efb, input int elat, input bit rangeOnly);
    bit acc;
    bit ok = 1'b0;
    if (push) begin
      qA.push_back(mkExp(ed, efb, elat, rangeOnly, mx));
      expCntA++;
    end
    req_valid = 1'b1;
    req_max = mx;
    for (int i = 0; i < 20; i++) begin
      #1;
      acc = req_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!ok) begin
      assertions++; failures++;
      $display("[TB] FAIL accept_timeout: got no acceptance, expected acceptance within 20 cycles");
    end
  endtask

  task automatic waitRespA();
    for (int i = 0; i < 100 && respCntA < expCntA; i++) tick();
    if (respCntA < expCntA) begin
      assertions++; failures++;
      $display("[TB] FAIL rspA_timeout: got %0d responses, expected %0d", respCntA, expCntA);
    end
  endtask

  task automatic waitRespB();
    for (int i = 0; i < 100 && respCntB < expCntB; i++) tick();
    if (respCntB < expCntB) begin
      assertions++; failures++;
      $display("[TB] FAIL rspB_timeout: got %0d responses, expected %0d", respCntB, expCntB);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0; req_valid = 1'b0; req_max = '0; rsp_ready = 1'b0;
    bEnable = 1'b0; bSeedLoad = 1'b0; bSeedIn = '0; bReqValid = 1'b0; bReqMax = '0; bRspReady = 1'b1;
    tick();
    tick();
    checkOutput("ready_in_reset", {15'h0, req_ready}, 16'h0);
    rst = 1'b0;
    #1;
    checkOutput("reset_random", random, 16'hACE1);
    checkOutput("reset_valid", {15'h0, rsp_valid}, 16'h0);
    checkOutput("reset_data", {8'h0, rsp_data}, 16'h0);
    checkOutput("reset_fallback", {15'h0, rsp_fallback}, 16'h0);

    repeat (5) tick();
    checkOutput("idle_hold_random", random, 16'hACE1);
    checkOutput("idle_hold_valid", {15'h0, rsp_valid}, 16'h0);
    enable = 1'b1;
    tick(); checkOutput("freerun_1", random, 16'hE270);
    tick(); checkOutput("freerun_2", random, 16'h7138);
    tick(); checkOutput("freerun_3", random, 16'h389C);
    enable = 1'b0;

    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(8'd255, 1'b1, 8'h70, 1'b0, 1, 1'b0);
    waitRespA();
    checkOutput("max255_random", random, 16'hE270);

    seed_load = 1'b1; seed_in = 16'h0E27; tick(); seed_load = 1'b0;
    checkOutput("seed_load_random", random, 16'h0E27);
    applyStimulus(8'd2, 1'b1, 8'd1, 1'b0, 2, 1'b0);
    waitRespA();
    checkOutput("reject_random", random, 16'hED89);

    bSeedLoad = 1'b1; bSeedIn = 16'h0E27; tick(); bSeedLoad = 1'b0;
    qB.push_back(mkExp(8'd0, 1'b1, 1, 1'b0, 8'd2));
    expCntB++;
    bReqValid = 1'b1; bReqMax = 8'd2;
    #1;
    checkOutput("b_ready", {15'h0, bReqReady}, 16'h1);
    tick();
    bReqValid = 1'b0;
    waitRespB();
    checkOutput("b_random", bRandom, 16'hB313);

    seed_load = 1'b1; seed_in = 16'h0000; tick(); seed_load = 1'b0;
    checkOutput("zero_seed_guard", random, 16'hACE1);
    seed_load = 1'b1; seed_in = 16'h0E27; req_valid = 1'b1; req_max = 8'd2;
    #1;
    checkOutput("seed_vs_req_ready", {15'h0, req_ready}, 16'h0);
    tick();
    seed_load = 1'b0;
    checkOutput("seed_wins_random", random, 16'h0E27);
    applyStimulus(8'd2, 1'b1, 8'd1, 1'b0, 2, 1'b0);
    waitRespA();

    rsp_ready = 1'b0;
    applyStimulus(8'd255, 1'b0, 8'h0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", {15'h0, rsp_valid}, 16'h1);
      checkOutput("stall_data", {8'h0, rsp_data}, 16'h00C4);
      tick();
    end
    checkOutput("stall_fallback", {15'h0, rsp_fallback}, 16'h0);
    rst = 1'b1; tick();
    checkOutput("ready_in_reset2", {15'h0, req_ready}, 16'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_done_valid", {15'h0, rsp_valid}, 16'h0);
    checkOutput("rst_done_random", random, 16'hACE1);
    checkOutput("rst_done_ready", {15'h0, req_ready}, 16'h1);

    seed_load = 1'b1; seed_in = 16'h0E27; tick(); seed_load = 1'b0;
    applyStimulus(8'd2, 1'b0, 8'h0, 1'b0, 0, 1'b0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    checkOutput("rst_draw_valid", {15'h0, rsp_valid}, 16'h0);
    checkOutput("rst_draw_random", random, 16'hACE1);
    checkOutput("rst_draw_ready", {15'h0, req_ready}, 16'h1);

    rsp_ready = 1'b1;
    applyStimulus(8'd0, 1'b1, 8'd0, 1'b0, 1, 1'b0); waitRespA();
    applyStimulus(8'd5, 1'b1, 8'd0, 1'b0, 1, 1'b0); waitRespA();
    applyStimulus(8'd5, 1'b1, 8'd4, 1'b0, 1, 1'b0); waitRespA();

    for (int n = 0; n < 1000; n++) begin
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 8'h0, 1'b0, 0, 1'b1);
      waitRespA();
    end
    enable = 1'b0;
    tick();

    checkOutput("queueA_drained", 16'(qA.size()), 16'h0);
    checkOutput("queueB_drained", 16'(qB.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_ranged.md
Name: lfsr_rng_ranged

Overview:
- Parametrised Galois-LFSR random number generator that returns range-limited draws through a request/response handshake.
- Serves game control: duck spawn column, flight direction, spawn delays. Each consumer asks for a value in [0, req_max].
- Adds free-running entropy stepping, runtime seed load, lock-up protection, and rejection sampling with a bounded fallback.

Parameters:
- WIDTH, 16: LFSR register width.
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits. It must encode a maximal-length polynomial; the default is x^16+x^14+x^13+x^11+1.
- SEED, 16'hACE1: reset value and zero-substitute, WIDTH bits. Must be non-zero.
- OUT_W, 10: result and range width. Requires OUT_W <= WIDTH.
- STEPS_PER_DRAW, 1: LFSR steps per draw attempt. Must be >= 1.
- MAX_TRIES, 4: attempts before fallback. Must be >= 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- enable, input, 1: free-run stepping while IDLE.
- seed_load, input, 1: load seed_in (honoured in IDLE only).
- seed_in, input, WIDTH: new seed.
- req_valid, input, 1: draw request.
- req_ready, output, 1: request can be accepted.
- req_max, input, OUT_W: inclusive upper bound, sampled at acceptance.
- rsp_valid, output, 1: result available.
- rsp_ready, input, 1: consumer takes result.
- rsp_data, output, OUT_W: result in [0, latched max].
- rsp_fallback, output, 1: result came from the fallback path.
- random, output, WIDTH: current LFSR state (debug / raw use).

Behaviour:
- Galois step: nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). From 16'hACE1 the sequence is E270, 7138, 389C, 1C4E, 0E27, B313, ED89.
- Reset (on a clk edge with rst=1): lfsr=SEED, state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_fallback=0. Reset mid-draw abandons the draw; no response is produced.
- Lock-up guard: any load of all-zeros (seed_in=0) writes SEED instead. The LFSR never holds 0.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - req_ready = !seed_load.
  - seed_load=1: lfsr <= seed_in (guarded); no step that cycle; a request is not accepted.
  - Otherwise, if req_valid: accept. Latch max=req_max and mask = smallest 2^k-1 >= req_max (OR-fold of req_max). Clear try_cnt and step_cnt. Go to DRAW. The LFSR does not step on the acceptance edge.
  - Otherwise, if enable: one step per cycle.
- DRAW:
  - req_ready=0. One step every cycle; step_cnt counts to STEPS_PER_DRAW.
  - On the edge completing the last step, candidate = nxt[OUT_W-1:0] & mask.
  - If candidate <= max: rsp_data=candidate, rsp_fallback=0, go to DONE.
  - Else if try_cnt == MAX_TRIES-1: rsp_data = candidate - (max+1), rsp_fallback=1, go to DONE. This is always in range, since mask < 2*(max+1).
  - Else: try_cnt++, step_cnt=0, stay in DRAW.
  - enable and seed_load are ignored in DRAW.
- DONE:
  - rsp_valid=1; rsp_data and rsp_fallback are held stable until the handshake.
  - The LFSR holds.
  - rsp_valid && rsp_ready: go to IDLE; rsp_valid drops the next cycle.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency: rsp_valid rises STEPS_PER_DRAW*attempts cycles after the request handshake edge, where attempts is at most MAX_TRIES.
- Boundaries:
  - req_max=0: mask=0, candidate is always 0, accepted on the first attempt.
  - req_max=all-ones: mask=all-ones, never rejected.
  - seed_load and req_valid in the same IDLE cycle: the seed wins and the request stays pending.
  - rsp_ready held high continuously is legal and gives a one-cycle DONE.
- random always reflects the registered lfsr.

Test Plan:
- Reset, enable=0, idle 5 cycles -> random stays 16'hACE1, rsp_valid=0. Then enable=1 for 3 cycles -> random = E270, 7138, 389C.
- From reset (OUT_W=8, STEPS=1): req req_max=255, rsp_ready=1 -> rsp_valid exactly 1 cycle after acceptance, rsp_data=8'h70, rsp_fallback=0, random=E270.
- Seed load 16'h0E27, then req req_max=2 -> attempt 1 gives B313&3=3 (rejected), attempt 2 gives ED89&3=1. Required: rsp_data=1, rsp_fallback=0, latency 2 cycles.
- Same as the previous test with MAX_TRIES=1 -> rsp_data=0 (3-3), rsp_fallback=1, latency 1 cycle.
- seed_load with seed_in=0 -> random=16'hACE1. seed_load and req_valid in the same cycle -> req_ready=0 that cycle; request accepted the next cycle.
- rsp_ready held low 10 cycles, then rst asserted mid-DONE, plus a second run with rst mid-DRAW -> rsp_data stable while waiting; after reset rsp_valid=0, state IDLE, random=16'hACE1. A random 1000-request run checks every result <= req_max.
